// File: rtl/sequence_presenter.sv
// rtl/sequence_presenter.sv - LFSR-driven button-code sequence generator, presenter and streamer
//
// Purpose: on start, draws STEPS 4-bit codes from a 16-bit Fibonacci LFSR into a
// buffer, shows each code for SHOW_CYCLES followed by GAP_CYCLES of blank, then
// streams the codes to a checker over a valid/ready handshake and pulses done.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   start      - begin a new stage sequence (honoured only in IDLE)
//   seed_load  - load LFSR from seed (honoured only in IDLE, wins over start)
//   seed       - 16-bit LFSR seed; zero is replaced by 16'hACE1
//   show_code  - code shown to the player
//   show_on    - show_code is valid for display
//   seq_code   - expected code streamed to the checker
//   seq_index  - position of seq_code
//   seq_valid  - seq_code / seq_index are valid
//   seq_ready  - checker accepts the current code
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse when the sequence completes

module sequence_presenter #(
    parameter int STEPS       = 8,
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 12_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [3:0]  show_code,
    output logic        show_on,
    output logic [3:0]  seq_code,
    output logic [3:0]  seq_index,
    output logic        seq_valid,
    input  logic        seq_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_SHOW,
        S_GAP,
        S_STREAM,
        S_DONE
    } state_t;

    localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [3:0]    LAST_STEP = 4'(STEPS - 1);
    localparam logic [15:0]   LFSR_INIT = 16'hACE1;

    state_t        state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   lfsr_adv;
    // Sized for the largest legal STEPS so step can index it directly.
    logic [3:0]    buffer_q [16];
    logic [3:0]    buffer_d [16];

    logic [3:0]    show_code_q, show_code_d;
    logic          show_on_q, show_on_d;
    logic [3:0]    seq_code_q, seq_code_d;
    logic [3:0]    seq_index_q, seq_index_d;
    logic          seq_valid_q, seq_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        timer_d  = timer_q;
        lfsr_d   = lfsr_q;
        buffer_d = buffer_q;

        case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    // Zero would lock the LFSR, so it is never loaded.
                    lfsr_d = (seed == 16'h0000) ? LFSR_INIT : seed;
                end else if (start) begin
                    state_d = S_GEN;
                    step_d  = 4'd0;
                end
            end
            S_GEN: begin
                lfsr_d           = lfsr_adv;
                buffer_d[step_q] = lfsr_adv[3:0];
                if (step_q == LAST_STEP) begin
                    state_d = S_SHOW;
                    step_d  = 4'd0;
                    timer_d = SHOW_LOAD;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            S_SHOW: begin
                if (timer_q == '0) begin
                    state_d = S_GAP;
                    timer_d = GAP_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_GAP: begin
                if (timer_q == '0) begin
                    if (step_q == LAST_STEP) begin
                        state_d = S_STREAM;
                        step_d  = 4'd0;
                    end else begin
                        state_d = S_SHOW;
                        step_d  = step_q + 4'd1;
                        timer_d = SHOW_LOAD;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_STREAM: begin
                if (seq_valid_q && seq_ready) begin
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                        step_d  = 4'd0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        show_on_d   = (state_d == S_SHOW);
        show_code_d = (state_d == S_SHOW) ? buffer_d[step_d] : 4'd0;
        seq_valid_d = (state_d == S_STREAM);
        seq_code_d  = (state_d == S_STREAM) ? buffer_d[step_d] : 4'd0;
        seq_index_d = (state_d == S_STREAM) ? step_d : 4'd0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= 4'd0;
            timer_q     <= '0;
            lfsr_q      <= LFSR_INIT;
            for (int i = 0; i < 16; i++) begin
                buffer_q[i] <= 4'd0;
            end
            show_code_q <= 4'd0;
            show_on_q   <= 1'b0;
            seq_code_q  <= 4'd0;
            seq_index_q <= 4'd0;
            seq_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            timer_q     <= timer_d;
            lfsr_q      <= lfsr_d;
            for (int i = 0; i < 16; i++) begin
                buffer_q[i] <= buffer_d[i];
            end
            show_code_q <= show_code_d;
            show_on_q   <= show_on_d;
            seq_code_q  <= seq_code_d;
            seq_index_q <= seq_index_d;
            seq_valid_q <= seq_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign show_code = show_code_q;
    assign show_on   = show_on_q;
    assign seq_code  = seq_code_q;
    assign seq_index = seq_index_q;
    assign seq_valid = seq_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sequence_presenter.sv
// tb/tb_sequence_presenter.sv - self-checking bench for sequence_presenter

module tb_sequence_presenter;

    localparam int STEPS  = 8;
    localparam int SHOW   = 3;
    localparam int GAP    = 2;
    localparam int PERIOD = SHOW + GAP;
    localparam int RUN_LEN = STEPS + STEPS * PERIOD;   // GEN + SHOW/GAP cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        seed_load;
    logic [15:0] seed;
    logic [3:0]  show_code;
    logic        show_on;
    logic [3:0]  seq_code;
    logic [3:0]  seq_index;
    logic        seq_valid;
    logic        seq_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sequence_presenter #(
        .STEPS(STEPS),
        .SHOW_CYCLES(SHOW),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .seed_load(seed_load),
        .seed(seed),
        .show_code(show_code),
        .show_on(show_on),
        .seq_code(seq_code),
        .seq_index(seq_index),
        .seq_valid(seq_valid),
        .seq_ready(seq_ready),
        .busy(busy),
        .done(done)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    // Reference model: phase 0 idle, 1 running (GEN+SHOW/GAP timeline), 2 stream, 3 done.
    int          m_phase = 0;
    int          m_k     = 0;
    int          m_idx   = 0;
    logic [15:0] m_lfsr  = 16'hACE1;
    logic [3:0]  m_seq [STEPS];
    bit          m_live  = 0;
    int          cyc     = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_phase = 0;
            m_k     = 0;
            m_idx   = 0;
            m_lfsr  = 16'hACE1;
            m_live  = 1;
        end else begin
            case (m_phase)
                0: begin
                    if (seed_load) m_lfsr = (seed == 0) ? 16'hACE1 : seed;
                    else if (start) begin
                        for (int i = 0; i < STEPS; i++) begin
                            m_lfsr   = lfsr_next(m_lfsr);
                            m_seq[i] = m_lfsr[3:0];
                        end
                        m_phase = 1;
                        m_k     = 1;
                    end
                end
                1: begin
                    if (m_k == RUN_LEN) begin
                        m_phase = 2;
                        m_idx   = 0;
                    end else m_k++;
                end
                2: begin
                    if (seq_ready) begin
                        if (m_idx == STEPS - 1) m_phase = 3;
                        else m_idx++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle compare plus event capture.
    logic [3:0] cap [$];
    int  show_rises = 0, show_high = 0, done_cnt = 0;
    int  busy_cyc = 0, valid_cyc = 0;
    logic p_busy = 0, p_valid = 0, p_show = 0;

    always @(negedge clk) begin
        logic [15:0] e, a;
        int j, r;
        if (m_live) begin
            e = '0;
            if (m_phase != 0) e[15] = 1'b1;
            if (m_phase == 3) e[14] = 1'b1;
            if (m_phase == 1 && m_k > STEPS) begin
                j = (m_k - STEPS - 1) / PERIOD;
                r = (m_k - STEPS - 1) % PERIOD;
                if (r < SHOW) begin
                    e[13]    = 1'b1;
                    e[12:9]  = m_seq[j];
                end
            end
            if (m_phase == 2) begin
                e[8]   = 1'b1;
                e[7:4] = m_seq[m_idx];
                e[3:0] = 4'(m_idx);
            end
            a = {busy, done, show_on, show_code, seq_valid, seq_code, seq_index};
            n_total++;
            if (a === e) n_pass++;
            else $display("FAIL cycle_compare cyc=%0d actual=%h required=%h", cyc, a, e);
        end
        if (busy && !p_busy) busy_cyc = cyc;
        if (seq_valid && !p_valid) valid_cyc = cyc;
        if (show_on && !p_show) begin
            cap.push_back(show_code);
            show_rises++;
        end
        if (show_on) show_high++;
        if (done) done_cnt++;
        p_busy  = busy;
        p_valid = seq_valid;
        p_show  = show_on;
    end

    function automatic logic [31:0] pack_cap();
        logic [31:0] v = '0;
        for (int i = 0; i < cap.size() && i < 8; i++) v[i*4 +: 4] = cap[i];
        return v;
    endfunction

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic do_seed(input logic [15:0] s);
        @(negedge clk); seed_load = 1'b1; seed = s;
        @(negedge clk); seed_load = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == base) chk({nm, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    logic [31:0] cap_a, cap_l1, cap_l2;
    int d0, h0, r0, n;

    initial begin
        rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed = 16'h0; seq_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, done, show_on, show_code, seq_valid, seq_code, seq_index}, 32'h0);
        rst = 1'b0;

        // Sequence straight after reset: LFSR starts at ACE1.
        cap.delete(); h0 = show_high; d0 = done_cnt;
        do_start();
        wait_done("after_reset");
        cap_a = pack_cap();
        chk("ace1_code0", 32'(cap[0]), 32'd3);
        chk("ace1_code1", 32'(cap[1]), 32'd7);
        chk("show_count", 32'(cap.size()), 32'd8);
        chk("show_high_cycles", 32'(show_high - h0), 32'd24);
        chk("first_valid_latency", 32'(valid_cyc - busy_cyc), 32'd48);
        chk("done_once_a", 32'(done_cnt - d0), 32'd1);

        // Seed 1 gives 2,4,8,0,0,0,0,0.
        do_seed(16'h0001);
        cap.delete(); d0 = done_cnt;
        do_start();
        wait_done("seed1");
        chk("seed1_codes", pack_cap(), 32'h0000_0842);
        chk("seed1_model", {m_seq[7], m_seq[6], m_seq[5], m_seq[4], m_seq[3], m_seq[2], m_seq[1], m_seq[0]}, 32'h0000_0842);
        chk("done_once_seed1", 32'(done_cnt - d0), 32'd1);

        // Zero seed is equivalent to a fresh reset.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        do_seed(16'h0000);
        cap.delete();
        do_start();
        wait_done("zero_seed");
        chk("zero_seed_codes", pack_cap(), cap_a);

        // Backpressure in STREAM.
        seq_ready = 1'b0;
        do_start();
        n = 0;
        while (!seq_valid && n < 200) begin @(negedge clk); n++; end
        chk("bp_reached_stream", 32'(seq_valid), 32'd1);
        repeat (5) @(negedge clk);
        chk("bp_index_held", 32'(seq_index), 32'd0);
        seq_ready = 1'b1;
        @(negedge clk); seq_ready = 1'b0;
        chk("bp_one_advance", 32'(seq_index), 32'd1);
        repeat (3) @(negedge clk);
        chk("bp_index_still", 32'(seq_index), 32'd1);
        seq_ready = 1'b1;
        wait_done("backpressure");

        // start/seed_load during GAP are ignored; the next run differs.
        cap.delete(); r0 = show_rises;
        do_start();
        n = 0;
        while (!(busy && !show_on && show_rises > r0) && n < 200) begin @(negedge clk); n++; end
        start = 1'b1; seed_load = 1'b1; seed = 16'h1234;
        @(negedge clk); start = 1'b0; seed_load = 1'b0;
        wait_done("lockout");
        cap_l1 = pack_cap();
        cap.delete();
        do_start();
        wait_done("fresh");
        cap_l2 = pack_cap();
        chk("fresh_sequence_differs", 32'(cap_l1 != cap_l2), 32'd1);

        // Reset during SHOW of step 3, start held high meanwhile.
        d0 = done_cnt; r0 = show_rises;
        do_start();
        n = 0;
        while (show_rises < r0 + 4 && n < 200) begin @(negedge clk); n++; end
        chk("reached_step3", 32'(show_rises - r0), 32'd4);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {busy, done, show_on, show_code, seq_valid, seq_code, seq_index}, 32'h0);
        @(negedge clk); rst = 1'b0; start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_idle", 32'(busy), 32'd0);
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
